// File: rtl/write_image_if.sv
// Image sink bus: byte stream in (valid/ready), packed word writes out.
interface write_image_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;

    // Stream source / buffer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/write_image.sv
// Image byte sink: packs bytes little-endian into 64-bit words and writes
// each word to a word-addressed buffer. Byte i lands in lane i%8 of word i/8.

// One byte lane of the packing register. nxt is the lane value including a
// byte being loaded this cycle, so a completed word can be written directly.
module write_image_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] din,
    output logic [7:0] nxt
);
    logic [7:0] q;

    assign nxt = ld ? din : q;

    // Lane storage; cleared once its word has been written out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (ld)  q <= din;
    end
endmodule

module write_image #(
    parameter int NUM_BYTES  = 200,
    parameter int WORD_BYTES = 8,
    parameter int NUM_WORDS  = (NUM_BYTES + 7) / 8,
    parameter int ADDR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    parameter int CNT_W      = $clog2(NUM_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    write_image_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_count
);
    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]                cnt_q;
    logic [LANE_W-1:0]               lane_q;
    logic [ADDR_W-1:0]               word_q;
    logic                            wr_en_q;
    logic [ADDR_W-1:0]               wr_addr_q;
    logic [63:0]                     wr_data_q;
    logic [WORD_BYTES-1:0][7:0]      nxt_word;

    logic run, accept, last_byte, word_done, start_ok, clr;

    // Ready is a pure state decode, so accept never loops through the FSM.
    assign run       = (state_q == RUN);
    assign accept    = bus.in_valid & run;
    assign last_byte = accept && (cnt_q == LAST_BYTE);
    assign word_done = accept && ((lane_q == LAST_LANE) || (cnt_q == LAST_BYTE));
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign clr       = start_ok | word_done;

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
        write_image_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .ld    (accept && (lane_q == LANE_W'(g))),
            .din   (bus.in_data),
            .nxt   (nxt_word[g])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and state-decoded status outputs.
    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (last_byte) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters and the registered write port; a word completed on the
    // accepting edge is presented for exactly the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            lane_q    <= '0;
            word_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= word_done;
            if (start_ok) begin
                cnt_q  <= '0;
                lane_q <= '0;
                word_q <= '0;
            end else if (accept) begin
                cnt_q  <= cnt_q + 1'b1;
                lane_q <= word_done ? '0 : lane_q + 1'b1;
                if (word_done) begin
                    wr_addr_q <= word_q;
                    wr_data_q <= nxt_word;
                    word_q    <= word_q + 1'b1;
                end
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign byte_count  = cnt_q;
endmodule
